// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared state/mode encodings and duty constants for the PWM fader
package pwm_fade_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD_HI,
        ST_RAMP_DN,
        ST_HOLD_LO
    } state_t;

    typedef enum logic [1:0] {
        MODE_TRIANGLE,
        MODE_SAWTOOTH,
        MODE_BLINK,
        MODE_FIXED_HALF
    } mode_t;

    localparam logic [6:0] DUTY_MAX   = 7'd127;
    localparam logic [6:0] DUTY_HALF  = 7'd63;
    localparam int         PWM_PERIOD = 128;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: turns a bouncing active-high button into a single one-cycle press pulse
module btn_debounce
    import pwm_fade_pkg::*;
#(
    parameter logic [11:0] DEB_LEN = 12'h1FF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_pulse
);

    logic [11:0] r_cnt;
    logic        r_sat;
    logic        r_pulse;

    // count consecutive high cycles; pulse once on the cycle after the count first saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= 12'd0;
            r_sat   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= !i_raw ? 12'd0 : (r_cnt == DEB_LEN) ? r_cnt : r_cnt + 12'd1;
            r_sat   <= (r_cnt == DEB_LEN);
            r_pulse <= (r_cnt == DEB_LEN) && !r_sat;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: button-driven LED fade sequencer feeding a 128-step period-aligned PWM
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter logic [11:0] STEP_DIV   = 12'd98,
    parameter logic [7:0]  HOLD_STEPS = 8'd32,
    parameter logic [11:0] DEB_LEN    = 12'h1FF
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic        w_clk;
    logic        w_rst;
    logic        w_mode_pulse;
    logic        w_run_pulse;
    logic        w_tick;
    logic        w_hold_done;
    logic        w_unused;
    mode_t       w_mode_eff;
    mode_t       r_mode;
    state_t      r_state;
    state_t      w_state;
    logic        r_running;
    logic        w_running;
    logic [6:0]  r_duty_next;
    logic [6:0]  w_duty_next;
    logic [6:0]  r_duty_active;
    logic [6:0]  r_cnt;
    logic [11:0] r_pre;
    logic [11:0] w_pre;
    logic [7:0]  r_hold;
    logic [7:0]  w_hold;
    logic        r_pwm;

    assign w_clk    = io_in[0];
    assign w_rst    = io_in[1];
    assign w_unused = &{1'b0, io_in[7:4]};

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_mode (
        .i_clk  (w_clk),
        .i_rst  (w_rst),
        .i_raw  (io_in[2]),
        .o_pulse(w_mode_pulse)
    );

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_run (
        .i_clk  (w_clk),
        .i_rst  (w_rst),
        .i_raw  (io_in[3]),
        .o_pulse(w_run_pulse)
    );

    assign w_tick      = r_running && (r_pre == STEP_DIV - 12'd1);
    assign w_hold_done = (r_hold == HOLD_STEPS - 8'd1);
    // mode only advances in IDLE, and a start on the same cycle sees the advanced mode
    assign w_mode_eff  = (r_state == ST_IDLE && w_mode_pulse) ? next_mode(r_mode) : r_mode;

    // sequencer next state, duty target, hold and prescaler counters
    always_comb begin
        w_state     = r_state;
        w_running   = r_running;
        w_duty_next = r_duty_next;
        w_hold      = r_hold;
        w_pre       = (w_tick || !r_running) ? 12'd0 : r_pre + 12'd1;
        if (r_state == ST_IDLE) begin
            if (w_run_pulse) begin
                w_running = 1'b1;
                w_pre     = 12'd0;
                w_hold    = 8'd0;
                w_state   = (w_mode_eff == MODE_BLINK || w_mode_eff == MODE_FIXED_HALF) ? ST_HOLD_HI : ST_RAMP_UP;
                if (w_mode_eff == MODE_BLINK) w_duty_next = DUTY_MAX;
                if (w_mode_eff == MODE_FIXED_HALF) w_duty_next = DUTY_HALF;
            end
        end else if (w_run_pulse) begin
            w_running = 1'b0;
            w_state   = ST_IDLE;
            w_pre     = 12'd0;
        end else if (w_tick) begin
            case (r_state)
                ST_RAMP_UP: begin
                    w_duty_next = (r_duty_next == DUTY_MAX) ? DUTY_MAX : r_duty_next + 7'd1;
                    if (r_duty_next >= DUTY_MAX - 7'd1) begin
                        w_state = ST_HOLD_HI;
                        w_hold  = 8'd0;
                    end
                end
                ST_RAMP_DN: begin
                    w_duty_next = (r_duty_next == 7'd0) ? 7'd0 : r_duty_next - 7'd1;
                    if (r_duty_next <= 7'd1) begin
                        w_state = ST_HOLD_LO;
                        w_hold  = 8'd0;
                    end
                end
                ST_HOLD_HI: begin
                    if (r_mode != MODE_FIXED_HALF) begin
                        w_hold = w_hold_done ? 8'd0 : r_hold + 8'd1;
                        if (w_hold_done) begin
                            w_state = (r_mode == MODE_TRIANGLE) ? ST_RAMP_DN : ST_HOLD_LO;
                            if (r_mode != MODE_TRIANGLE) w_duty_next = 7'd0;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    w_hold = w_hold_done ? 8'd0 : r_hold + 8'd1;
                    if (w_hold_done) begin
                        w_state = (r_mode == MODE_BLINK) ? ST_HOLD_HI : ST_RAMP_UP;
                        if (r_mode == MODE_BLINK) w_duty_next = DUTY_MAX;
                    end
                end
                default: ;
            endcase
        end
    end

    // sequencer state register
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) r_state <= ST_IDLE;
        else r_state <= w_state;
    end

    // mode, run flag, duty, counters and PWM output; duty_active swaps only at period end
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_mode        <= MODE_TRIANGLE;
            r_running     <= 1'b0;
            r_duty_next   <= DUTY_HALF;
            r_duty_active <= DUTY_HALF;
            r_cnt         <= 7'd0;
            r_pre         <= 12'd0;
            r_hold        <= 8'd0;
            r_pwm         <= 1'b0;
        end else begin
            r_mode      <= w_mode_eff;
            r_running   <= w_running;
            r_duty_next <= w_duty_next;
            r_pre       <= w_pre;
            r_hold      <= w_hold;
            r_cnt       <= r_cnt + 7'd1;
            if (r_cnt == 7'(PWM_PERIOD - 1)) r_duty_active <= r_duty_next;
            r_pwm       <= r_cnt < r_duty_active;
        end
    end

    assign io_out = {2'b00, r_mode, r_running, r_duty_active == 7'd0, r_duty_active == DUTY_MAX, r_pwm};

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed scoreboard bench for the PWM fade controller
module tb_pwm_fade_ctrl;
    import pwm_fade_pkg::*;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_run  = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int    n_assert = 0;
    int    n_fail   = 0;
    string q_tag[$];
    int    q_exp[$];

    int n, pos, p, npulse, highs;
    int st[108];
    int dn[108];
    int rn[108];

    assign io_in = {4'b1010, btn_run, btn_mode, rst, clk};

    pwm_fade_ctrl #(
        .STEP_DIV  (12'd4),
        .HOLD_STEPS(8'd2),
        .DEB_LEN   (12'd8)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic m, input logic r);
        btn_mode = m;
        btn_run  = r;
        cyc(10);
        btn_mode = 1'b0;
        btn_run  = 1'b0;
    endtask

    task automatic expect_v(input string t, input int v);
        q_tag.push_back(t);
        q_exp.push_back(v);
    endtask

    task automatic sb_check(input int obs);
        string t;
        int    e;
        n_assert++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d required=none", obs);
            return;
        end
        t = q_tag.pop_front();
        e = q_exp.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d required=%0d", t, obs, e);
        end
    endtask

    task automatic pwm_window(output int h);
        int k;
        k = 0;
        while (dut.r_cnt != 7'd0 && k < 200) begin
            cyc(1);
            k++;
        end
        h = 0;
        repeat (128) begin
            h += int'(io_out[0]);
            cyc(1);
        end
    endtask

    initial begin
        // reset state
        expect_v("rst_pwm", 0);
        expect_v("rst_at_max", 0);
        expect_v("rst_at_min", 0);
        expect_v("rst_running", 0);
        expect_v("rst_mode", 0);
        expect_v("rst_hi_bits", 0);
        expect_v("rst_duty_active", 63);
        expect_v("rst_duty_next", 63);
        expect_v("rst_state", int'(ST_IDLE));
        cyc(3);
        sb_check(io_out[0]);
        sb_check(io_out[1]);
        sb_check(io_out[2]);
        sb_check(io_out[3]);
        sb_check(io_out[5:4]);
        sb_check(io_out[7:6]);
        sb_check(dut.r_duty_active);
        sb_check(dut.r_duty_next);
        sb_check(dut.r_state);
        rst = 1'b0;
        expect_v("idle_pwm_highs", 63);
        pwm_window(highs);
        sb_check(highs);

        // held run button: single pulse, start into RAMP_UP, first step after STEP_DIV cycles
        expect_v("run_pulse_count", 1);
        expect_v("run_pulse_cycle", 8);
        expect_v("start_state", int'(ST_RAMP_UP));
        expect_v("start_running", 1);
        expect_v("duty_before_tick", 63);
        expect_v("duty_first_tick", 64);
        btn_run = 1'b1;
        npulse  = 0;
        pos     = -1;
        for (int i = 0; i < 108; i++) begin
            cyc(1);
            if (dut.w_run_pulse) begin
                npulse++;
                if (pos < 0) pos = i;
            end
            st[i] = int'(dut.r_state);
            dn[i] = int'(dut.r_duty_next);
            rn[i] = int'(io_out[3]);
        end
        btn_run = 1'b0;
        p = (pos < 0 || pos > 90) ? 0 : pos;
        sb_check(npulse);
        sb_check(pos);
        sb_check(st[p+1]);
        sb_check(rn[p+1]);
        sb_check(dn[p+4]);
        sb_check(dn[p+5]);

        // triangle: top, two-tick hold, descent, stop in HOLD_LO at duty 0
        expect_v("tri_reach_top", 1);
        expect_v("tri_top_state", int'(ST_HOLD_HI));
        expect_v("tri_hold_cycles", 8);
        expect_v("tri_dn_state", int'(ST_RAMP_DN));
        expect_v("tri_dn_duty", 127);
        expect_v("tri_reach_two", 1);
        n = 0;
        while (dut.r_duty_next != 7'd127 && n < 2000) begin cyc(1); n++; end
        sb_check(n < 2000);
        sb_check(dut.r_state);
        n = 0;
        while (dut.r_state == ST_HOLD_HI && n < 50) begin cyc(1); n++; end
        sb_check(n);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        n = 0;
        while (!(dut.r_state == ST_RAMP_DN && dut.r_duty_next == 7'd2) && n < 2000) begin cyc(1); n++; end
        sb_check(n < 2000);
        expect_v("tri_stop_state", int'(ST_IDLE));
        expect_v("tri_stop_duty", 0);
        expect_v("tri_stop_running", 0);
        expect_v("at_min_seen", 1);
        expect_v("at_min_boundary", 0);
        expect_v("at_min_not_max", 0);
        expect_v("zero_duty_highs", 0);
        press(1'b0, 1'b1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        sb_check(io_out[3]);
        n = 0;
        while (!io_out[2] && n < 300) begin cyc(1); n++; end
        sb_check(n < 300);
        sb_check(dut.r_cnt);
        sb_check(io_out[1]);
        pwm_window(highs);
        sb_check(highs);

        // ramp up from 0, stop inside HOLD_HI so duty 127 is retained
        expect_v("up_start_state", int'(ST_RAMP_UP));
        press(1'b0, 1'b1);
        sb_check(dut.r_state);
        expect_v("up_reach_125", 1);
        n = 0;
        while (!(dut.r_state == ST_RAMP_UP && dut.r_duty_next == 7'd125) && n < 2000) begin cyc(1); n++; end
        sb_check(n < 2000);
        expect_v("hi_stop_state", int'(ST_IDLE));
        expect_v("hi_stop_duty", 127);
        expect_v("hi_stop_running", 0);
        expect_v("at_max_seen", 1);
        expect_v("at_max_boundary", 0);
        expect_v("at_max_not_min", 0);
        expect_v("max_duty_highs", 127);
        press(1'b0, 1'b1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        sb_check(io_out[3]);
        n = 0;
        while (!io_out[1] && n < 300) begin cyc(1); n++; end
        sb_check(n < 300);
        sb_check(dut.r_cnt);
        sb_check(io_out[2]);
        pwm_window(highs);
        sb_check(highs);

        // simultaneous mode+run in IDLE: sawtooth starts at 127, holds, drops, restarts
        expect_v("sim_mode", 1);
        expect_v("sim_state", int'(ST_RAMP_UP));
        expect_v("sim_running", 1);
        expect_v("saw_pre_tick", int'(ST_RAMP_UP));
        expect_v("saw_top_state", int'(ST_HOLD_HI));
        expect_v("saw_top_duty", 127);
        expect_v("saw_hold_state", int'(ST_HOLD_HI));
        expect_v("saw_lo_state", int'(ST_HOLD_LO));
        expect_v("saw_lo_duty", 0);
        expect_v("saw_restart_state", int'(ST_RAMP_UP));
        expect_v("saw_restart_duty", 1);
        press(1'b1, 1'b1);
        sb_check(io_out[5:4]);
        sb_check(dut.r_state);
        sb_check(io_out[3]);
        cyc(3);
        sb_check(dut.r_state);
        cyc(1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        cyc(7);
        sb_check(dut.r_state);
        cyc(1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        cyc(8);
        sb_check(dut.r_state);
        cyc(4);
        sb_check(dut.r_duty_next);
        expect_v("mode_ignored_running", 1);
        expect_v("mode_ignored_still_run", 1);
        press(1'b1, 1'b0);
        sb_check(io_out[5:4]);
        sb_check(io_out[3]);
        expect_v("saw_stop_state", int'(ST_IDLE));
        expect_v("saw_stop_running", 0);
        press(1'b0, 1'b1);
        sb_check(dut.r_state);
        sb_check(io_out[3]);

        // blink: 2 ticks full, 2 ticks off, period-aligned duty
        expect_v("blink_mode", 2);
        expect_v("blink_start_state", int'(ST_HOLD_HI));
        expect_v("blink_start_duty", 127);
        expect_v("blink_hi_state", int'(ST_HOLD_HI));
        expect_v("blink_lo_state", int'(ST_HOLD_LO));
        expect_v("blink_lo_duty", 0);
        expect_v("blink_hi2_state", int'(ST_HOLD_HI));
        expect_v("blink_hi2_duty", 127);
        expect_v("blink_window1_whole", 1);
        expect_v("blink_window2_whole", 1);
        press(1'b1, 1'b0);
        sb_check(io_out[5:4]);
        press(1'b0, 1'b1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        cyc(7);
        sb_check(dut.r_state);
        cyc(1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        cyc(8);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        pwm_window(highs);
        sb_check(highs == 0 || highs == 127);
        pwm_window(highs);
        sb_check(highs == 0 || highs == 127);
        press(1'b0, 1'b1);

        // fixed half: holds forever at 63
        expect_v("half_mode", 3);
        expect_v("half_state", int'(ST_HOLD_HI));
        expect_v("half_duty", 63);
        expect_v("half_still_hold", int'(ST_HOLD_HI));
        expect_v("half_running", 1);
        expect_v("half_highs", 63);
        expect_v("half_at_max", 0);
        expect_v("half_at_min", 0);
        press(1'b1, 1'b0);
        sb_check(io_out[5:4]);
        press(1'b0, 1'b1);
        sb_check(dut.r_state);
        sb_check(dut.r_duty_next);
        cyc(40);
        sb_check(dut.r_state);
        sb_check(io_out[3]);
        pwm_window(highs);
        sb_check(highs);
        sb_check(io_out[1]);
        sb_check(io_out[2]);
        press(1'b0, 1'b1);

        // reset mid-descent at duty 40
        expect_v("wrap_mode", 0);
        expect_v("dn40_reached", 1);
        press(1'b1, 1'b0);
        sb_check(io_out[5:4]);
        press(1'b0, 1'b1);
        n = 0;
        while (!(dut.r_state == ST_RAMP_DN && dut.r_duty_next == 7'd40) && n < 3000) begin cyc(1); n++; end
        sb_check(n < 3000);
        expect_v("arst_pwm", 0);
        expect_v("arst_duty_active", 63);
        expect_v("arst_duty_next", 63);
        expect_v("arst_state", int'(ST_IDLE));
        expect_v("arst_running", 0);
        expect_v("arst_at_max", 0);
        expect_v("arst_at_min", 0);
        #2;
        rst = 1'b1;
        #1;
        sb_check(io_out[0]);
        sb_check(dut.r_duty_active);
        sb_check(dut.r_duty_next);
        sb_check(dut.r_state);
        sb_check(io_out[3]);
        sb_check(io_out[1]);
        sb_check(io_out[2]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_v("post_rst_pulses", 0);
        expect_v("post_rst_running", 0);
        expect_v("post_rst_state", int'(ST_IDLE));
        expect_v("post_rst_mode", 0);
        expect_v("post_rst_duty", 63);
        npulse = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (dut.w_run_pulse || dut.w_mode_pulse) npulse++;
        end
        sb_check(npulse);
        sb_check(io_out[3]);
        sb_check(dut.r_state);
        sb_check(io_out[5:4]);
        sb_check(dut.r_duty_next);

        n_assert++;
        assert (q_exp.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d required=0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
